// File: rtl/rep_word_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rep_word_serializer_if
//  Description : Handshake bundle for the replicated-word serializer. Carries
//                the word-in stream (in_*), the byte-out stream (out_*) and
//                the replication error flag.
//                master = upstream source plus downstream consumer
//                slave  = the serializer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface rep_word_serializer_if #(
    parameter int BYTE_W = 8,
    parameter int NBYTES = 4
);
    // Word-in stream
    logic [BYTE_W*NBYTES-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;

    // Byte-out stream
    logic [BYTE_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    // Sticky replication-check flag
    logic                     rep_err;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  rep_err
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
        output rep_err
    );
endinterface
`default_nettype wire

// File: rtl/rep_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : rep_word_serializer
//  Description : Takes one BYTE_W*NBYTES word per handshake and emits it as
//                NBYTES bytes on a valid/ready byte stream, flagging the last
//                byte of each word. A new word can be loaded on the same edge
//                that the last byte leaves, so consecutive words stream with
//                no idle cycle.
//                Optional feature macro: REP_CHECK_EN
//                  defined   - every accepted word is checked for being a
//                              true byte replication; rep_err is sticky
//                              until rst.
//                  undefined - no check logic, rep_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module rep_word_serializer #(
    parameter int BYTE_W    = 8,
    parameter int NBYTES    = 4,      // must be >= 2
    parameter bit MSB_FIRST = 1'b1    // 1: top byte first, 0: bottom byte first
) (
    input  logic                 clk,
    input  logic                 rst,
    rep_word_serializer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_WORD_W = BYTE_W * NBYTES;
    localparam int c_CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    // Index of the final byte of a word, and of the byte just before it.
    localparam logic [c_CNT_W-1:0] c_LAST_CNT   = c_CNT_W'(NBYTES - 1);
    localparam logic [c_CNT_W-1:0] c_PENULT_CNT = c_CNT_W'(NBYTES - 2);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;       // index of the byte on out_data
    logic [c_WORD_W-1:0] r_shift;     // bytes still to be presented
    logic [BYTE_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_last;

    // ------------------------------------------------------------------------
    // Byte selection.
    // r_shift always holds the bytes that follow the one currently on
    // out_data, with the next one to go sitting at the "emit end" of the
    // register. Loading a word therefore splits it into its first byte
    // (straight to the output register) and the remainder shifted by one
    // byte; advancing repeats the same split on r_shift.
    // ------------------------------------------------------------------------
    logic [BYTE_W-1:0]   w_in_first;  // first byte of the incoming word
    logic [c_WORD_W-1:0] w_in_rest;   // incoming word with first byte removed
    logic [BYTE_W-1:0]   w_sh_next;   // next byte waiting in r_shift
    logic [c_WORD_W-1:0] w_sh_rest;   // r_shift with that byte removed

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_in_first = bus.in_data[c_WORD_W-1 -: BYTE_W];
            assign w_in_rest  = {bus.in_data[c_WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            assign w_sh_next  = r_shift[c_WORD_W-1 -: BYTE_W];
            assign w_sh_rest  = {r_shift[c_WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        end else begin : g_lsb_first
            assign w_in_first = bus.in_data[BYTE_W-1:0];
            assign w_in_rest  = {{BYTE_W{1'b0}}, bus.in_data[c_WORD_W-1:BYTE_W]};
            assign w_sh_next  = r_shift[BYTE_W-1:0];
            assign w_sh_rest  = {{BYTE_W{1'b0}}, r_shift[c_WORD_W-1:BYTE_W]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake decode.
    // in_ready is built only from registered state and out_ready, so there is
    // no combinational path from in_valid back to in_ready. It opens in IDLE,
    // and in SHIFT only on the cycle the final byte is being consumed.
    // ------------------------------------------------------------------------
    logic w_out_fire;   // consumer takes the current byte
    logic w_last_fire;  // consumer takes the final byte of the word
    logic w_in_ready;
    logic w_in_fire;    // a new word is accepted this cycle

    assign w_out_fire  = r_out_valid & bus.out_ready;
    assign w_last_fire = w_out_fire & r_out_last;
    assign w_in_ready  = (r_state == S_IDLE) | w_last_fire;
    assign w_in_fire   = bus.in_valid & w_in_ready;

    // ------------------------------------------------------------------------
    // Serializer FSM: word load, byte advance, zero-bubble reload and drain.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_state     <= S_SHIFT;
                        r_cnt       <= '0;
                        r_shift     <= w_in_rest;
                        r_out_data  <= w_in_first;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (c_LAST_CNT == '0);
                    end
                end

                S_SHIFT: begin
                    if (w_in_fire) begin
                        // Final byte leaves and the next word enters on the
                        // same edge: restart the count, stay in SHIFT.
                        r_cnt       <= '0;
                        r_shift     <= w_in_rest;
                        r_out_data  <= w_in_first;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (c_LAST_CNT == '0);
                    end else if (w_out_fire) begin
                        if (!r_out_last) begin
                            // Present the next byte of the same word.
                            r_cnt       <= r_cnt + 1'b1;
                            r_shift     <= w_sh_rest;
                            r_out_data  <= w_sh_next;
                            r_out_last  <= (r_cnt == c_PENULT_CNT);
                        end else begin
                            // Word finished and nothing waiting upstream.
                            r_state     <= S_IDLE;
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                    // Otherwise the consumer is stalling: hold everything.
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

    // ------------------------------------------------------------------------
    // Replication check
    // ------------------------------------------------------------------------
`ifdef REP_CHECK_EN
    logic [NBYTES-1:0] w_byte_diff;  // bit i set: byte i differs from byte 0
    logic              r_rep_err;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_rep_cmp
            assign w_byte_diff[gi] =
                (bus.in_data[gi*BYTE_W +: BYTE_W] != bus.in_data[BYTE_W-1:0]);
        end
    endgenerate

    // Sticky error: set by any accepted word that is not a pure replication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_err <= 1'b0;
        end else if (w_in_fire && (|w_byte_diff)) begin
            r_rep_err <= 1'b1;
        end
    end

    assign bus.rep_err = r_rep_err;
`else
    assign bus.rep_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rep_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rep_word_serializer
//  Description : Self-checking bench for rep_word_serializer. Two instances
//                share one stimulus stream: one emits top byte first, the
//                other bottom byte first. Directed scenarios plus a random
//                run checked against a byte-queue reference model.
//                Honours REP_CHECK_EN for the rep_err expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rep_word_serializer;

    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = BYTE_W * NBYTES;

`ifdef REP_CHECK_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rep_word_serializer_if #(.BYTE_W(BYTE_W), .NBYTES(NBYTES)) bus_m ();
    rep_word_serializer_if #(.BYTE_W(BYTE_W), .NBYTES(NBYTES)) bus_l ();

    // The bottom-first instance sees exactly the same stimulus.
    assign bus_l.in_data   = bus_m.in_data;
    assign bus_l.in_valid  = bus_m.in_valid;
    assign bus_l.out_ready = bus_m.out_ready;

    rep_word_serializer #(.BYTE_W(BYTE_W), .NBYTES(NBYTES), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    rep_word_serializer #(.BYTE_W(BYTE_W), .NBYTES(NBYTES), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    // Byte k of word w in emission order.
    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k, input bit msb);
        int sh;
        sh = msb ? 8 * (NBYTES - 1 - k) : 8 * k;
        return 8'((w >> sh) & 32'h0000_00FF);
    endfunction

    function automatic bit is_rep(input logic [31:0] w);
        return w == {4{w[7:0]}};
    endfunction

    task automatic drive(input bit v, input logic [31:0] d, input bit r);
        bus_m.in_valid  = v;
        bus_m.in_data   = d;
        bus_m.out_ready = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_m.out_valid); end
        checks++; if (bus_m.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus_m.out_data); end
        checks++; if (bus_m.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus_m.out_last); end
        checks++; if (bus_m.rep_err !== 1'b0) begin errors++; $display("FAIL reset_rep_err: got %b want 0", bus_m.rep_err); end
        checks++; if (bus_m.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus_m.in_ready); end
        checks++; if (bus_l.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_lsb: got %b want 0", bus_l.out_valid); end
        checks++; if (bus_l.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_lsb: got %b want 1", bus_l.in_ready); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single;
        logic [31:0] w;
        w = 32'h0202_0202;
        drive(1'b1, w, 1'b1);
        #1;
        checks++; if (bus_m.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", bus_m.in_ready); end
        tick;
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            checks++; if (bus_m.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", k, bus_m.out_valid); end
            checks++; if (bus_m.out_data !== byte_at(w, k, 1'b1)) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", k, bus_m.out_data, byte_at(w, k, 1'b1)); end
            checks++; if (bus_m.out_last !== (k == NBYTES - 1)) begin errors++; $display("FAIL single_last[%0d]: got %b want %b", k, bus_m.out_last, (k == NBYTES - 1)); end
            checks++; if (bus_m.rep_err !== 1'b0) begin errors++; $display("FAIL single_rep_err[%0d]: got %b want 0", k, bus_m.rep_err); end
            tick;
        end
        checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus_m.out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back;
        logic [31:0] w0, w1, w;
        w0 = 32'h7E7E_7E7E;
        w1 = 32'hFCFC_FCFC;
        drive(1'b1, w0, 1'b1);
        tick;
        bus_m.in_data = w1;   // in_valid stays high
        for (int k = 0; k < 2 * NBYTES; k++) begin
            if (k == NBYTES) bus_m.in_valid = 1'b0;
            w = (k < NBYTES) ? w0 : w1;
            #1;
            checks++; if (bus_m.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, bus_m.out_valid); end
            checks++; if (bus_m.out_data !== byte_at(w, k % NBYTES, 1'b1)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, bus_m.out_data, byte_at(w, k % NBYTES, 1'b1)); end
            checks++; if (bus_m.out_last !== (k % NBYTES == NBYTES - 1)) begin errors++; $display("FAIL b2b_last[%0d]: got %b want %b", k, bus_m.out_last, (k % NBYTES == NBYTES - 1)); end
            checks++; if (bus_m.in_ready !== (k % NBYTES == NBYTES - 1)) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, bus_m.in_ready, (k % NBYTES == NBYTES - 1)); end
            tick;
        end
        checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus_m.out_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure;
        logic [31:0] w;
        int          idx;
        w = 32'h6B6B_6B6B;
        drive(1'b1, w, 1'b1);
        tick;
        bus_m.in_valid = 1'b0;
        // Stall three cycles while byte 1 is on the bus: 7 valid cycles total.
        for (int c = 0; c < 8; c++) begin
            bus_m.out_ready = !(c >= 1 && c <= 3);
            idx = (c == 0) ? 0 : (c <= 4) ? 1 : c - 3;
            #1;
            if (c < 7) begin
                checks++; if (bus_m.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus_m.out_valid); end
                checks++; if (bus_m.out_data !== byte_at(w, idx, 1'b1)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", c, bus_m.out_data, byte_at(w, idx, 1'b1)); end
                checks++; if (bus_m.out_last !== (c == 6)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", c, bus_m.out_last, (c == 6)); end
                checks++; if (bus_m.in_ready !== (c == 6)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, bus_m.in_ready, (c == 6)); end
            end else begin
                checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", bus_m.out_valid); end
            end
            tick;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_order_err;
        logic [31:0] w;
        w = 32'h1234_5678;
        drive(1'b1, w, 1'b1);
        tick;
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            checks++; if (bus_m.out_data !== byte_at(w, k, 1'b1)) begin errors++; $display("FAIL order_msb[%0d]: got %h want %h", k, bus_m.out_data, byte_at(w, k, 1'b1)); end
            checks++; if (bus_l.out_data !== byte_at(w, k, 1'b0)) begin errors++; $display("FAIL order_lsb[%0d]: got %h want %h", k, bus_l.out_data, byte_at(w, k, 1'b0)); end
            checks++; if (bus_m.rep_err !== REP_EN) begin errors++; $display("FAIL order_rep_err[%0d]: got %b want %b", k, bus_m.rep_err, REP_EN); end
            checks++; if (bus_l.rep_err !== REP_EN) begin errors++; $display("FAIL order_rep_err_lsb[%0d]: got %b want %b", k, bus_l.rep_err, REP_EN); end
            tick;
        end
        // A clean word afterwards must not clear the sticky flag.
        w = 32'h5555_5555;
        drive(1'b1, w, 1'b1);
        tick;
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            checks++; if (bus_m.rep_err !== REP_EN) begin errors++; $display("FAIL sticky_rep_err[%0d]: got %b want %b", k, bus_m.rep_err, REP_EN); end
            tick;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_midword;
        logic [31:0] w;
        w = 32'hA8A8_A8A8;
        drive(1'b1, w, 1'b1);
        tick;
        bus_m.in_valid = 1'b0;
        tick;
        tick;
        checks++; if (bus_m.out_valid !== 1'b1 || bus_m.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got valid %b last %b want 1 0", bus_m.out_valid, bus_m.out_last); end
        // Reset while byte 2 is on the bus; a word offered alongside is ignored.
        rst = 1'b1;
        drive(1'b1, 32'h9999_9999, 1'b0);
        tick;
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus_m.out_valid); end
        checks++; if (bus_m.out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", bus_m.out_data); end
        checks++; if (bus_m.rep_err !== 1'b0) begin errors++; $display("FAIL rstmid_rep_err: got %b want 0", bus_m.rep_err); end
        checks++; if (bus_m.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus_m.in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d]: got %b want 0", c, bus_m.out_valid); end
        end
        w = 32'h0202_0202;
        drive(1'b1, w, 1'b1);
        tick;
        bus_m.in_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            checks++; if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 8'h02) begin errors++; $display("FAIL rstmid_next[%0d]: got valid %b data %h want 1 02", k, bus_m.out_valid, bus_m.out_data); end
            checks++; if (bus_m.out_last !== (k == NBYTES - 1)) begin errors++; $display("FAIL rstmid_next_last[%0d]: got %b want %b", k, bus_m.out_last, (k == NBYTES - 1)); end
            tick;
        end
        checks++; if (bus_m.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_end: got %b want 0", bus_m.out_valid); end
    endtask

    // ------------------------------------------------------------------------
    // Random traffic against a byte-queue model: bytes still owed to the
    // consumer for each instance, plus the sticky error bit.
    task automatic test_random;
        logic [7:0]  qa[$];
        logic [7:0]  qb[$];
        bit          err_m;
        bit          pend;
        bit          exp_ready;
        bit          acc_in;
        bit          v;
        bit          r;
        logic [31:0] d;

        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        err_m = 1'b0;
        pend  = 1'b0;
        d     = '0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++; if (bus_m.out_valid !== (qa.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, bus_m.out_valid, (qa.size() != 0)); end
            checks++; if (bus_l.out_valid !== (qb.size() != 0)) begin errors++; $display("FAIL rnd_valid_lsb[%0d]: got %b want %b", cyc, bus_l.out_valid, (qb.size() != 0)); end
            if (qa.size() != 0) begin
                checks++; if (bus_m.out_data !== qa[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, bus_m.out_data, qa[0]); end
                checks++; if (bus_m.out_last !== (qa.size() == 1)) begin errors++; $display("FAIL rnd_last[%0d]: got %b want %b", cyc, bus_m.out_last, (qa.size() == 1)); end
            end
            if (qb.size() != 0) begin
                checks++; if (bus_l.out_data !== qb[0]) begin errors++; $display("FAIL rnd_data_lsb[%0d]: got %h want %h", cyc, bus_l.out_data, qb[0]); end
            end
            checks++; if (bus_m.rep_err !== (REP_EN && err_m)) begin errors++; $display("FAIL rnd_rep_err[%0d]: got %b want %b", cyc, bus_m.rep_err, (REP_EN && err_m)); end

            // A word offered but not taken must be held unchanged.
            if (pend) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 39) == 0)
                    d = $urandom;
                else
                    d = {4{8'($urandom_range(0, 255))}};
            end
            r = ($urandom_range(0, 99) < 75);
            drive(v, d, r);
            #1;

            exp_ready = (qa.size() == 0) || (qa.size() == 1 && r);
            checks++; if (bus_m.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", cyc, bus_m.in_ready, exp_ready); end
            checks++; if (bus_l.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready_lsb[%0d]: got %b want %b", cyc, bus_l.in_ready, exp_ready); end

            acc_in = v && exp_ready;
            if (qa.size() != 0 && r) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc_in) begin
                for (int k = 0; k < NBYTES; k++) begin
                    qa.push_back(byte_at(d, k, 1'b1));
                    qb.push_back(byte_at(d, k, 1'b0));
                end
                if (!is_rep(d)) err_m = 1'b1;
            end
            pend = v && !acc_in;
            tick;
        end
        drive(1'b0, '0, 1'b1);
        for (int c = 0; c < NBYTES + 1; c++) tick;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_order_err;
        test_reset_midword;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
